// File: rtl/palette_pkg.sv
// Shared types and constants for the palette zone painter.
package palette_pkg;
   localparam int PAL_COLOR_W = 24;
   typedef logic [PAL_COLOR_W-1:0] color_t;

   localparam color_t DEF_COLOR_STEP = 24'h010203;
   localparam color_t BLANK_COLOR    = '0;

   function automatic int unsigned zone_idx(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
      return row * cols + col;
   endfunction
endpackage

// File: rtl/palette_zone_painter_swap_pulse_gen.sv
// Swap button conditioning: synchroniser, optional debounce, rising-edge pulse.
// PALETTE_DEBOUNCE_EN adds a stability counter ahead of the edge detector.
module swap_pulse_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic swap_i,
   output logic pulse_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl;
   logic                   prev_q;
   logic                   pulse_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], swap_i};
   end

`ifdef PALETTE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             deb_q;

   // Any return to the debounced level restarts the stability count.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == deb_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_q <= '0;
         deb_q <= sync_q[SYNC_STAGES-1];
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
   assign lvl = deb_q;
`else
   assign lvl = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= lvl;
         pulse_q <= lvl & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;
endmodule

// File: rtl/palette_zone_painter.sv
// Zone painter: per-zone palette fed by a free-running colour generator.
// Optional PALETTE_DEBOUNCE_EN debounces the swap button.
module palette_zone_painter
   import palette_pkg::*;
#(
   parameter int                  COLOR_W         = 24,
   parameter int                  ZONE_COLS       = 2,
   parameter int                  ZONE_ROWS       = 2,
   parameter int                  H_ACTIVE        = 640,
   parameter int                  V_ACTIVE        = 480,
   parameter logic [COLOR_W-1:0]  COLOR_STEP      = COLOR_W'(DEF_COLOR_STEP),
   parameter int                  SYNC_STAGES     = 2,
   parameter int                  DEBOUNCE_CYCLES = 16,
   localparam int                 NUM_ZONES       = ZONE_COLS * ZONE_ROWS,
   localparam int                 PTR_W           = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               swap_in,
   input  logic [9:0]         horizontal,
   input  logic [9:0]         vertical,
   output logic [COLOR_W-1:0] color,
   output logic [PTR_W-1:0]   wr_ptr,
   output logic               palette_full
);
   localparam int unsigned ZW = H_ACTIVE / ZONE_COLS;
   localparam int unsigned ZH = V_ACTIVE / ZONE_ROWS;

   logic [COLOR_W-1:0] gen_q;
   logic [COLOR_W-1:0] pal_q [NUM_ZONES];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               full_q;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               swap_pulse;
   logic [31:0]        h32, v32;
   logic [PTR_W-1:0]   col, row, zone;

   swap_pulse_gen #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_swap (
      .clk_i  (clk_in),
      .rst_n_i(reset_in),
      .swap_i (swap_in),
      .pulse_o(swap_pulse)
   );

   assign h32 = {22'd0, horizontal};
   assign v32 = {22'd0, vertical};

   // Compare chain against constant zone boundaries; saturates at the last zone.
   always_comb begin
      col = '0;
      row = '0;
      for (int k = 1; k < ZONE_COLS; k++)
         if (h32 >= k * ZW) col = PTR_W'(k);
      for (int k = 1; k < ZONE_ROWS; k++)
         if (v32 >= k * ZH) row = PTR_W'(k);
      zone = PTR_W'(zone_idx(int'(row), int'(col), ZONE_COLS));
   end

   always_comb begin
      color_d = COLOR_W'(BLANK_COLOR);
      if (h32 < H_ACTIVE && v32 < V_ACTIVE) color_d = pal_q[zone];
   end

   assign wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_ZONES - 1)) ? '0 : wr_ptr_q + 1'b1;

   // Output samples the palette before this cycle's write, so a colliding
   // write shows up one cycle later.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         gen_q    <= '0;
         wr_ptr_q <= '0;
         full_q   <= 1'b0;
         color_q  <= '0;
         for (int i = 0; i < NUM_ZONES; i++) pal_q[i] <= '0;
      end else begin
         gen_q   <= gen_q + COLOR_STEP;
         color_q <= color_d;
         if (swap_pulse) begin
            pal_q[wr_ptr_q] <= gen_q;
            wr_ptr_q        <= wr_ptr_d;
            if (wr_ptr_q == PTR_W'(NUM_ZONES - 1)) full_q <= 1'b1;
         end
      end
   end

   assign color        = color_q;
   assign wr_ptr       = wr_ptr_q;
   assign palette_full = full_q;
endmodule

// File: tb/tb_palette_zone_painter.sv
// Directed bench for palette_zone_painter (2x2 zones, 640x480, step 24'h010203).
// Honours PALETTE_DEBOUNCE_EN by adding the debounce delay to expected write values.
module tb_palette_zone_painter;
   localparam logic [23:0] STEP = 24'h010203;
`ifdef PALETTE_DEBOUNCE_EN
   localparam int EXTRA = 16;
`else
   localparam int EXTRA = 0;
`endif

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b0;
   logic        swap_in = 1'b0;
   logic [9:0]  horizontal = '0;
   logic [9:0]  vertical = '0;
   logic [23:0] color;
   logic [1:0]  wr_ptr;
   logic        palette_full;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [23:0] p [5];
   logic [23:0] v_old, v_new;

   palette_zone_painter #(.DEBOUNCE_CYCLES(16)) dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .swap_in     (swap_in),
      .horizontal  (horizontal),
      .vertical    (vertical),
      .color       (color),
      .wr_ptr      (wr_ptr),
      .palette_full(palette_full)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      @(negedge clk_in);
      cyc++;
   endtask

   task automatic do_reset();
      reset_in = 1'b0;
      swap_in  = 1'b0;
      repeat (3) tick();
      reset_in = 1'b1;
      cyc = 0;
   endtask

   // Write lands 4 edges after the raise (+debounce), capturing gen as of edge cyc+3.
   task automatic press(output logic [23:0] val);
      val = 24'((cyc + 3 + EXTRA) * STEP);
      swap_in = 1'b1;
      repeat (10 + EXTRA) tick();
      swap_in = 1'b0;
      repeat (5 + EXTRA) tick();
   endtask

   task automatic pix(input int h, input int v);
      horizontal = 10'(h);
      vertical   = 10'(v);
      tick();
   endtask

   initial begin
      // Reset state at pixel (100,100)
      horizontal = 10'd100; vertical = 10'd100;
      reset_in = 1'b0;
      repeat (3) tick();
      chk("rst_color", color, 0);
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_full", palette_full, 0);
      reset_in = 1'b1; cyc = 0;
      tick();
      chk("post_rst_color", color, 0);

      // Single swap: raise after 7 edges so gen = 10*STEP at the write
      do_reset();
      horizontal = 10'd10; vertical = 10'd10;
      repeat (7) tick();
      swap_in = 1'b1;
      repeat (50 + EXTRA) tick();
      swap_in = 1'b0;
      repeat (5 + EXTRA) tick();
      chk("single_wr_ptr", wr_ptr, 1);
      pix(10, 10);
      chk("single_color", color, 24'h0A141E);

      // Round robin over 4 slots, wrapping to slot 0 on the 5th press
      do_reset();
      horizontal = 10'd10; vertical = 10'd10;
      for (int i = 0; i < 5; i++) begin
         press(p[i]);
         chk($sformatf("rr_ptr%0d", i), wr_ptr, (i + 1) % 4);
         chk($sformatf("rr_full%0d", i), palette_full, (i >= 3) ? 1 : 0);
      end
      pix(0, 0);     chk("px_0_0", color, p[4]);
      pix(639, 0);   chk("px_639_0", color, p[1]);
      pix(0, 479);   chk("px_0_479", color, p[2]);
      pix(639, 479); chk("px_639_479", color, p[3]);

      // Blanking and zone boundaries
      pix(640, 0);   chk("blank_h640", color, 0);
      pix(0, 480);   chk("blank_v480", color, 0);
      pix(639, 480); chk("blank_639_480", color, 0);
      pix(319, 239); chk("bnd_319_239", color, p[4]);
      pix(320, 239); chk("bnd_320_239", color, p[1]);
      pix(319, 240); chk("bnd_319_240", color, p[2]);
      pix(320, 240); chk("bnd_320_240", color, p[3]);

      // Advance wr_ptr back to slot 0, then collide with the displayed slot
      for (int i = 1; i < 4; i++) press(p[i]);
      chk("coll_ptr", wr_ptr, 0);
      horizontal = 10'd10; vertical = 10'd10;
      v_old = p[4];
      v_new = 24'((cyc + 3 + EXTRA) * STEP);
      swap_in = 1'b1;
      repeat (4 + EXTRA) tick();
      chk("coll_old", color, v_old);
      tick();
      chk("coll_new", color, v_new);
      swap_in = 1'b0;
      repeat (5 + EXTRA) tick();

      // Mid-line reset with a pending swap in the synchroniser
      swap_in = 1'b1;
      repeat (2) tick();
      reset_in = 1'b0;
      tick();
      chk("mid_rst_color", color, 0);
      chk("mid_rst_ptr", wr_ptr, 0);
      chk("mid_rst_full", palette_full, 0);
      reset_in = 1'b1; swap_in = 1'b0; cyc = 0;
      repeat (10 + EXTRA) tick();
      chk("mid_rst_no_pulse", wr_ptr, 0);
      pix(639, 479); chk("mid_rst_pal_clr", color, 0);

`ifdef PALETTE_DEBOUNCE_EN
      // A 10-cycle glitch is shorter than the debounce window
      swap_in = 1'b1;
      repeat (10) tick();
      swap_in = 1'b0;
      repeat (40) tick();
      chk("deb_glitch", wr_ptr, 0);
      horizontal = 10'd10; vertical = 10'd10;
      v_new = 24'((cyc + 3 + 16) * STEP);
      swap_in = 1'b1;
      repeat (20) tick();
      swap_in = 1'b0;
      repeat (30) tick();
      chk("deb_ptr", wr_ptr, 1);
      pix(10, 10); chk("deb_color", color, v_new);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
